// File: rtl/cov_pkg.sv
// cov_pkg: shared widths and line FSM encoding for the coefficient tap generator.
package cov_pkg;
  localparam int PIX_W  = 10;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int COL_W  = 12;
  localparam int ADDR_W = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_e;
endpackage

// File: rtl/cov_coef_bank.sv
// cov_coef_bank: shadow coefficient bank with a deferred commit into the active bank.
module cov_coef_bank
  import cov_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coef_we_i,
  input  logic [ADDR_W-1:0]             coef_addr_i,
  input  logic [COEF_W-1:0]             coef_in_i,
  input  logic                          coef_commit_i,
  input  logic                          idle_i,
  output logic [TAPS-1:0][COEF_W-1:0]   k_o,
  output logic                          busy_o
);
  logic [TAPS-1:0][COEF_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic pending_q, pending_d;
  // The copy waits for a line boundary so a whole line is filtered with one kernel.
  always_comb begin
    pending_d = pending_q ? ~idle_i : coef_commit_i;
    active_d  = (pending_q & idle_i) ? shadow_q : active_q;
    shadow_d  = shadow_q;
    if (coef_we_i) shadow_d[coef_addr_i] = coef_in_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end
  assign k_o    = active_q;
  assign busy_o = pending_q;
endmodule

// File: rtl/cov_tap_gen.sv
// cov_tap_gen: builds an 8-pixel sliding window per image line and presents it
// with a line-stable coefficient set.
module cov_tap_gen
  import cov_pkg::*;
#(
  parameter int LINE_W = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_en,
  input  logic              line_clr,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_commit,
  output logic [PIX_W-1:0]  din1,
  output logic [PIX_W-1:0]  din2,
  output logic [PIX_W-1:0]  din3,
  output logic [PIX_W-1:0]  din4,
  output logic [PIX_W-1:0]  din5,
  output logic [PIX_W-1:0]  din6,
  output logic [PIX_W-1:0]  din7,
  output logic [PIX_W-1:0]  din8,
  output logic [COEF_W-1:0] k1,
  output logic [COEF_W-1:0] k2,
  output logic [COEF_W-1:0] k3,
  output logic [COEF_W-1:0] k4,
  output logic [COEF_W-1:0] k5,
  output logic [COEF_W-1:0] k6,
  output logic [COEF_W-1:0] k7,
  output logic [COEF_W-1:0] k8,
  output logic              tap_en,
  output logic              line_end,
  output logic              commit_busy
);
  state_e state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, col_inc;
  logic [TAPS-1:0][PIX_W-1:0] win_q, win_d;
  logic [TAPS-1:0][COEF_W-1:0] k;
  logic tap_q, tap_d, end_q, end_d, accept, last;
  always_comb begin
    accept  = pix_en & ~line_clr;
    last    = col_q == COL_W'(LINE_W - 1);
    col_inc = last ? '0 : col_q + 1'b1;
    col_d   = line_clr ? '0 : accept ? col_inc : col_q;
    state_d = line_clr ? IDLE : !accept ? state_q : last ? IDLE :
              (col_inc >= COL_W'(TAPS)) ? RUN : FILL;
    win_d   = line_clr ? '0 : accept ? {pix_in, win_q[TAPS-1:1]} : win_q;
    tap_d   = accept & (col_q >= COL_W'(TAPS - 1));
    end_d   = accept & last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      win_q   <= '0;
      tap_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      win_q   <= win_d;
      tap_q   <= tap_d;
      end_q   <= end_d;
    end
  end
  cov_coef_bank u_bank (
    .clk          (clk),
    .rst          (rst),
    .coef_we_i    (coef_we),
    .coef_addr_i  (coef_addr),
    .coef_in_i    (coef_in),
    .coef_commit_i(coef_commit),
    .idle_i       (state_q == IDLE),
    .k_o          (k),
    .busy_o       (commit_busy)
  );
  assign {din8, din7, din6, din5, din4, din3, din2, din1} = win_q;
  assign {k8, k7, k6, k5, k4, k3, k2, k1} = k;
  assign tap_en   = tap_q;
  assign line_end = end_q;
endmodule

// File: tb/tb_cov_tap_gen.sv
// tb_cov_tap_gen: table vectors, directed corner sequences and random traffic
// against a pixel-history reference model.
module tb_cov_tap_gen;
  localparam int LW = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] pix_in = '0;
  logic pix_en = 1'b0, line_clr = 1'b0, coef_we = 1'b0, coef_commit = 1'b0;
  logic [2:0] coef_addr = '0;
  logic [7:0] coef_in = '0;
  logic [9:0] din1, din2, din3, din4, din5, din6, din7, din8;
  logic [7:0] k1, k2, k3, k4, k5, k6, k7, k8;
  logic tap_en, line_end, commit_busy;
  int total = 0, bad = 0;
  int hist[$];
  int cnt;
  logic [7:0] sh[8], act[8];
  bit pend, m_tap, m_le;
  typedef struct {
    bit en; bit clr; logic [9:0] pix;
    bit tap; bit le; logic [9:0] d1; logic [9:0] d8;
  } vec_t;
  vec_t tbl[$];

  cov_tap_gen #(.LINE_W(LW)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_en(pix_en), .line_clr(line_clr),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_in(coef_in), .coef_commit(coef_commit),
    .din1(din1), .din2(din2), .din3(din3), .din4(din4),
    .din5(din5), .din6(din6), .din7(din7), .din8(din8),
    .k1(k1), .k2(k2), .k3(k3), .k4(k4), .k5(k5), .k6(k6), .k7(k7), .k8(k8),
    .tap_en(tap_en), .line_end(line_end), .commit_busy(commit_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [79:0] exp_win();
    logic [79:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      int j = hist.size() - 8 + i;
      w[i*10 +: 10] = (j >= 0) ? 10'(hist[j]) : 10'd0;
    end
    return w;
  endfunction

  function automatic logic [79:0] exp_k();
    logic [79:0] w = '0;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = act[i];
    return w;
  endfunction

  function automatic logic [79:0] dut_win();
    return {din8, din7, din6, din5, din4, din3, din2, din1};
  endfunction

  function automatic logic [79:0] dut_k();
    return 80'({k8, k7, k6, k5, k4, k3, k2, k1});
  endfunction

  task automatic model_reset();
    hist.delete();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin sh[i] = '0; act[i] = '0; end
    pend = 0; m_tap = 0; m_le = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_window"}, dut_win(), exp_win());
    chk({tag, "_coef"}, dut_k(), exp_k());
    chk({tag, "_tap_en"}, 80'(tap_en), 80'(m_tap));
    chk({tag, "_line_end"}, 80'(line_end), 80'(m_le));
    chk({tag, "_busy"}, 80'(commit_busy), 80'(pend));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic step(input bit en, input logic [9:0] p, input bit clr, input bit we,
                      input logic [2:0] a, input logic [7:0] d, input bit cm, input string tag);
    pix_en = en; pix_in = p; line_clr = clr; coef_we = we; coef_addr = a; coef_in = d; coef_commit = cm;
    @(posedge clk);
    if (pend) begin
      if (cnt == 0) begin
        for (int i = 0; i < 8; i++) act[i] = sh[i];
        pend = 0;
      end
    end else pend = cm;
    if (we) sh[a] = d;
    m_tap = 0; m_le = 0;
    if (clr) begin
      hist.delete(); cnt = 0;
    end else if (en) begin
      m_tap = cnt >= 7; m_le = cnt == LW - 1;
      hist.push_back(int'(p));
      if (hist.size() > 8) void'(hist.pop_front());
      cnt = (cnt + 1) % LW;
    end
    #1;
    check_all(tag);
  endtask

  task automatic pix(input int p, input string tag);
    step(1'b1, 10'(p), 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 10'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, tag);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].en, tbl[i].pix, tbl[i].clr, 1'b0, 3'd0, 8'd0, 1'b0, "tblm");
      chk("tbl_tap", 80'(tap_en), 80'(tbl[i].tap));
      chk("tbl_le", 80'(line_end), 80'(tbl[i].le));
      chk("tbl_din1", 80'(din1), 80'(tbl[i].d1));
      chk("tbl_din8", 80'(din8), 80'(tbl[i].d8));
    end
  endtask

  initial begin
    for (int n = 1; n <= LW; n++)
      tbl.push_back('{1'b1, 1'b0, 10'(n), n >= 8, n == LW, (n >= 8) ? 10'(n - 7) : 10'd0, 10'(n)});
    for (int n = 1; n <= LW; n++) begin
      tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, (n > 8) ? 10'(n - 8) : 10'd0, 10'(n - 1)});
      tbl.push_back('{1'b1, 1'b0, 10'(n), n >= 8, n == LW, (n >= 8) ? 10'(n - 7) : 10'd0, 10'(n)});
    end
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;
    run_table(0, LW - 1);
    step(1'b0, 10'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, "preclr");
    run_table(LW, 3 * LW - 1);

    for (int s = 0; s < 8; s++) step(1'b0, 10'd0, 1'b0, 1'b1, 3'(s), 8'(s + 1), 1'b0, "wr33");
    step(1'b0, 10'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1, "commit33");
    chk("c33_busy", 80'(commit_busy), 80'd1);
    chk("c33_k_hold", dut_k(), 80'd0);
    idle("copy33");
    chk("c33_k", dut_k(), 80'h0807060504030201);
    chk("c33_busy_clr", 80'(commit_busy), 80'd0);

    for (int s = 0; s < 8; s++) step(1'b0, 10'd0, 1'b0, 1'b1, 3'(s), 8'(8'h11 + s), 1'b0, "wr34");
    for (int p = 1; p <= 5; p++) pix(p, "l34");
    step(1'b1, 10'd6, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1, "commit34");
    for (int p = 7; p <= LW; p++) begin
      pix(p, "l34");
      chk("c34_busy", 80'(commit_busy), 80'd1);
      chk("c34_k_hold", dut_k(), 80'h0807060504030201);
    end
    idle("copy34");
    chk("c34_k", dut_k(), 80'h1817161514131211);
    chk("c34_busy_clr", 80'(commit_busy), 80'd0);

    for (int p = 1; p <= 10; p++) pix(p, "l35");
    step(1'b1, 10'd11, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, "clr35");
    chk("c35_win", dut_win(), 80'd0);
    chk("c35_tap", 80'(tap_en), 80'd0);
    run_table(0, LW - 1);

    for (int p = 1; p <= 12; p++) pix(p, "l36");
    step(1'b0, 10'd0, 1'b0, 1'b1, 3'd0, 8'h55, 1'b1, "commit36");
    chk("c36_busy", 80'(commit_busy), 80'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("arst");
    chk("c36_zero", {dut_win(), tap_en, line_end, commit_busy} == '0 ? 80'd1 : 80'd0, 80'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle("post36");
    chk("c36_k", dut_k(), 80'd0);
    run_table(0, LW - 1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 10'($urandom), $urandom_range(0, 49) == 0,
           $urandom_range(0, 4) == 0, 3'($urandom), 8'($urandom), $urandom_range(0, 19) == 0, "rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
